// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI mode-0 main: one full-duplex DATA_W-bit frame per start
module spi_main #(
  parameter int DATA_W  = 128,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  // tx_sh holds the bits still to go out; its MSB is always the next sdo value,
  // because the current bit already sits in the sdo register.
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              half_done;

  // Every timed phase (lead, each sclk half, trail, gap) lasts CLK_DIV cycles.
  assign half_done = (div_cnt == DIV_LAST);

  // Frame sequencer: half-period timing, shift registers and all registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == IDLE || half_done) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= {tx_data[DATA_W-2:0], 1'b0};
            rx_sh   <= '0;
            bit_cnt <= '0;
            cs      <= 1'b0;
            sdo     <= tx_data[DATA_W-1];
            busy    <= 1'b1;
            state   <= LEAD;
          end
        end

        LEAD: begin
          if (half_done) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[DATA_W-2:0], sdi};
            state <= HIGH;
          end
        end

        HIGH: begin
          if (half_done) begin
            sclk <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              sdo     <= tx_sh[DATA_W-1];
              tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
              state   <= LOW;
            end else begin
              sdo   <= 1'b0;
              state <= TRAIL;
            end
          end
        end

        LOW: begin
          if (half_done) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[DATA_W-2:0], sdi};
            state <= HIGH;
          end
        end

        TRAIL: begin
          if (half_done) begin
            cs      <= 1'b1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            state   <= GAP;
          end
        end

        GAP: begin
          if (half_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_main.sv
// tb/tb_spi_main.sv - self-checking bench for spi_main (8-bit/div2 and 128-bit/div1 loopback)
module tb_spi_main;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Instance A: DATA_W=8, CLK_DIV=2, subordinate model on sdi
  logic       start_a;
  logic [7:0] tx_a;
  logic       busy_a, done_a, cs_a, sclk_a, sdo_a, sdi_a;
  logic [7:0] rx_a;

  // Instance B: DATA_W=128, CLK_DIV=1, sdo looped to sdi
  logic         start_b;
  logic [127:0] tx_b;
  logic         busy_b, done_b, cs_b, sclk_b, sdo_b, sdi_b;
  logic [127:0] rx_b;

  spi_main #(.DATA_W(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a),
    .cs(cs_a), .sclk(sclk_a), .sdo(sdo_a), .sdi(sdi_a)
  );

  spi_main #(.DATA_W(128), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b),
    .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b), .sdi(sdi_b)
  );

  assign sdi_b = sdo_b;

  // Subordinate model: loads its word when cs falls, shifts on each falling sclk.
  logic [7:0] sub_word = 8'h00;
  logic [7:0] sub_sh   = 8'h00;
  logic       pcs_a    = 1'b1;
  logic       psclk_a  = 1'b0;
  bit         sdo_q_a[$];
  int         cslow_a  = 0;
  int         done_n_a = 0;
  int         cslow_b  = 0;
  int         done_n_b = 0;

  assign sdi_a = sub_sh[7];

  always @(negedge clk) begin
    pcs_a   <= cs_a;
    psclk_a <= sclk_a;
    if (pcs_a && !cs_a) sub_sh <= sub_word;
    else if (!cs_a && psclk_a && !sclk_a) sub_sh <= {sub_sh[6:0], 1'b0};
    if (!psclk_a && sclk_a) sdo_q_a.push_back(sdo_a);
    if (!cs_a) cslow_a <= cslow_a + 1;
    if (done_a) done_n_a <= done_n_a + 1;
    if (!cs_b) cslow_b <= cslow_b + 1;
    if (done_b) done_n_b <= done_n_b + 1;
  end

  // One frame on instance A; poke>0 pulses start with a different word mid-frame.
  task automatic run_a(input logic [7:0] tx, input logic [7:0] sub, input int poke,
                       output logic [7:0] rx, output int lat, output int cs_low,
                       output int dones, output logic [7:0] sdo_word, output int rises);
    int qs, c0, d0, w;
    sub_word = sub;
    @(negedge clk);
    qs = sdo_q_a.size(); c0 = cslow_a; d0 = done_n_a;
    start_a = 1'b1; tx_a = tx;
    @(posedge clk);
    lat = 1;
    #1 start_a = 1'b0; tx_a = ~tx;
    rx = 8'h00;
    while (lat < 400) begin
      @(negedge clk);
      if (done_a) begin rx = rx_a; break; end
      if (lat == poke) begin start_a = 1'b1; tx_a = ~tx; end
      else start_a = 1'b0;
      @(posedge clk);
      lat++;
    end
    start_a = 1'b0;
    w = 0;
    while (busy_a && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    cs_low = cslow_a - c0;
    dones  = done_n_a - d0;
    rises  = sdo_q_a.size() - qs;
    sdo_word = 8'h00;
    for (int i = 0; i < rises && i < 8; i++) sdo_word = {sdo_word[6:0], sdo_q_a[qs+i]};
  endtask

  task automatic run_b(input logic [127:0] tx, input int poke, output logic [127:0] rx,
                       output int lat, output int cs_low, output int dones);
    int c0, d0, w;
    @(negedge clk);
    c0 = cslow_b; d0 = done_n_b;
    start_b = 1'b1; tx_b = tx;
    @(posedge clk);
    lat = 1;
    #1 start_b = 1'b0; tx_b = ~tx;
    rx = '0;
    while (lat < 1000) begin
      @(negedge clk);
      if (done_b) begin rx = rx_b; break; end
      if (lat == poke) begin start_b = 1'b1; tx_b = {tx[63:0], tx[127:64]} ^ 128'h1; end
      else start_b = 1'b0;
      @(posedge clk);
      lat++;
    end
    start_b = 1'b0;
    w = 0;
    while (busy_b && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    cs_low = cslow_b - c0;
    dones  = done_n_b - d0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (cs_a !== 1'b1) begin fails++; $display("FAIL reset_cs_a: got %b expected 1", cs_a); end
    tests++; if (sclk_a !== 1'b0) begin fails++; $display("FAIL reset_sclk_a: got %b expected 0", sclk_a); end
    tests++; if (sdo_a !== 1'b0) begin fails++; $display("FAIL reset_sdo_a: got %b expected 0", sdo_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
    tests++; if (rx_a !== 8'h00) begin fails++; $display("FAIL reset_rx_a: got %h expected 00", rx_a); end
    tests++; if (cs_b !== 1'b1) begin fails++; $display("FAIL reset_cs_b: got %b expected 1", cs_b); end
    tests++; if (rx_b !== 128'h0) begin fails++; $display("FAIL reset_rx_b: got %h expected 0", rx_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [7:0] rx, sw;
    int lat, csl, dn, rs;
    run_a(8'hA5, 8'h3C, -1, rx, lat, csl, dn, sw, rs);
    tests++; if (rs !== 8) begin fails++; $display("FAIL basic_rises: got %0d expected 8", rs); end
    tests++; if (sw !== 8'hA5) begin fails++; $display("FAIL basic_sdo: got %h expected a5", sw); end
    tests++; if (csl !== (2*8+1)*2) begin fails++; $display("FAIL basic_cs_low: got %0d expected %0d", csl, (2*8+1)*2); end
    tests++; if (lat !== (2*8+1)*2+1) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", lat, (2*8+1)*2+1); end
    tests++; if (rx !== 8'h3C) begin fails++; $display("FAIL basic_rx: got %h expected 3c", rx); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    tests++; if (rx_a !== 8'h3C) begin fails++; $display("FAIL basic_rx_hold: got %h expected 3c", rx_a); end
  endtask

  task automatic test_random_frames();
    logic [7:0] tx, sub, rx, sw;
    int lat, csl, dn, rs;
    for (int k = 0; k < 6; k++) begin
      tx  = 8'($urandom);
      sub = 8'($urandom);
      run_a(tx, sub, -1, rx, lat, csl, dn, sw, rs);
      tests++; if (rx !== sub) begin fails++; $display("FAIL rand_rx[%0d]: got %h expected %h", k, rx, sub); end
      tests++; if (sw !== tx) begin fails++; $display("FAIL rand_sdo[%0d]: got %h expected %h", k, sw, tx); end
      tests++; if (dn !== 1) begin fails++; $display("FAIL rand_done[%0d]: got %0d expected 1", k, dn); end
      tests++; if (csl !== 34) begin fails++; $display("FAIL rand_cs_low[%0d]: got %0d expected 34", k, csl); end
    end
  endtask

  task automatic test_loopback_128();
    logic [127:0] tx, rx;
    int lat, csl, dn;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) tx = 128'h00112233445566778899AABBCCDDEEFF;
      else tx = {$urandom, $urandom, $urandom, $urandom};
      run_b(tx, -1, rx, lat, csl, dn);
      tests++; if (rx !== tx) begin fails++; $display("FAIL loop_rx[%0d]: got %h expected %h", k, rx, tx); end
      tests++; if (dn !== 1) begin fails++; $display("FAIL loop_done[%0d]: got %0d expected 1", k, dn); end
      tests++; if (csl !== 2*128+1) begin fails++; $display("FAIL loop_cs_low[%0d]: got %0d expected %0d", k, csl, 2*128+1); end
      tests++; if (lat !== 2*128+2) begin fails++; $display("FAIL loop_latency[%0d]: got %0d expected %0d", k, lat, 2*128+2); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] tx, sub, rx, sw;
    logic [127:0] txb, rxb;
    int lat, csl, dn, rs;
    tx  = 8'($urandom);
    sub = 8'($urandom) | 8'h01;
    run_a(tx, sub, 12, rx, lat, csl, dn, sw, rs);
    tests++; if (rx !== sub) begin fails++; $display("FAIL busy_rx_a: got %h expected %h", rx, sub); end
    tests++; if (sw !== tx) begin fails++; $display("FAIL busy_sdo_a: got %h expected %h", sw, tx); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL busy_done_a: got %0d expected 1", dn); end
    txb = {$urandom, $urandom, $urandom, $urandom};
    run_b(txb, 100, rxb, lat, csl, dn);
    tests++; if (rxb !== txb) begin fails++; $display("FAIL busy_rx_b: got %h expected %h", rxb, txb); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL busy_done_b: got %0d expected 1", dn); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx, sw, sub2;
    int lat, csl, dn, rs, qs, d0, w;
    sub_word = 8'($urandom);
    @(negedge clk);
    qs = sdo_q_a.size(); d0 = done_n_a;
    start_a = 1'b1; tx_a = 8'($urandom);
    @(posedge clk);
    #1 start_a = 1'b0;
    w = 0;
    while ((sdo_q_a.size() - qs) < 3 && w < 200) begin @(negedge clk); w++; end
    tests++; if (w >= 200) begin fails++; $display("FAIL midrst_wait: got timeout expected 3 sclk rises"); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++; if (cs_a !== 1'b1) begin fails++; $display("FAIL midrst_cs: got %b expected 1", cs_a); end
    tests++; if (sclk_a !== 1'b0) begin fails++; $display("FAIL midrst_sclk: got %b expected 0", sclk_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    tests++; if (rx_a !== 8'h00) begin fails++; $display("FAIL midrst_rx: got %h expected 00", rx_a); end
    repeat (40) @(negedge clk);
    tests++; if (done_n_a !== d0) begin fails++; $display("FAIL midrst_no_done: got %0d expected %0d", done_n_a - d0, 0); end
    sub2 = 8'($urandom);
    run_a(8'hFF, sub2, -1, rx, lat, csl, dn, sw, rs);
    tests++; if (rx !== sub2) begin fails++; $display("FAIL midrst_after_rx: got %h expected %h", rx, sub2); end
    tests++; if (sw !== 8'hFF) begin fails++; $display("FAIL midrst_after_sdo: got %h expected ff", sw); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL midrst_after_done: got %0d expected 1", dn); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sub1, sub2, rx1, rx2;
    logic [15:0] sw;
    int qs, d0, w, hi, rs;
    sub1 = 8'($urandom);
    sub2 = 8'($urandom);
    rx1 = 8'h00; rx2 = 8'h00;
    sub_word = sub1;
    @(negedge clk);
    qs = sdo_q_a.size(); d0 = done_n_a;
    start_a = 1'b1; tx_a = 8'h01;
    @(posedge clk);
    #1 tx_a = 8'h80;
    w = 0;
    while (w < 200) begin @(negedge clk); if (done_a) break; w++; end
    rx1 = rx_a;
    sub_word = sub2;
    hi = (cs_a === 1'b1) ? 1 : 0;
    w = 0;
    while (w < 50) begin @(negedge clk); if (cs_a !== 1'b1) break; hi++; w++; end
    start_a = 1'b0;
    tests++; if (hi !== 3) begin fails++; $display("FAIL b2b_cs_high: got %0d expected 3", hi); end
    w = 0;
    while (w < 200) begin @(negedge clk); if (done_a) break; w++; end
    rx2 = rx_a;
    w = 0;
    while (busy_a && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    rs = sdo_q_a.size() - qs;
    sw = 16'h0000;
    for (int i = 0; i < rs && i < 16; i++) sw = {sw[14:0], sdo_q_a[qs+i]};
    tests++; if (done_n_a - d0 !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", done_n_a - d0); end
    tests++; if (rs !== 16) begin fails++; $display("FAIL b2b_rises: got %0d expected 16", rs); end
    tests++; if (sw !== 16'h0180) begin fails++; $display("FAIL b2b_sdo: got %h expected 0180", sw); end
    tests++; if (rx1 !== sub1) begin fails++; $display("FAIL b2b_rx1: got %h expected %h", rx1, sub1); end
    tests++; if (rx2 !== sub2) begin fails++; $display("FAIL b2b_rx2: got %h expected %h", rx2, sub2); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    tx_a    = 8'h00;
    start_b = 1'b0;
    tx_b    = '0;
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_loopback_128();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
